// File: rtl/traffic_pkg.sv
// Shared types and lamp encodings for the traffic light controller.
// Lamp vectors are {R,Y,G}.
package traffic_pkg;

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    AR1    = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
    AR2    = 3'd5,
    FLASH  = 3'd6
  } tl_state_e;

  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  // Returns {main_lamp, side_lamp} for a state; blink_on gates the FLASH pattern.
  function automatic logic [5:0] lamps_of(tl_state_e s, logic blink_on);
    logic [5:0] result;
    result = {LAMP_R, LAMP_R};
    case (s)
      MAIN_G:  result = {LAMP_G, LAMP_R};
      MAIN_Y:  result = {LAMP_Y, LAMP_R};
      SIDE_G:  result = {LAMP_R, LAMP_G};
      SIDE_Y:  result = {LAMP_R, LAMP_Y};
      FLASH:   result = blink_on ? {LAMP_Y, LAMP_R} : {LAMP_OFF, LAMP_OFF};
      default: result = {LAMP_R, LAMP_R};
    endcase
    return result;
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// Signal bundle between the controller, its phase timer and the pedestrian/maintenance inputs.
// master drives the timer pulses and requests; slave is the controller.
interface traffic_light_ctrl_if;
  logic       green_end;
  logic       yellow_end;
  logic       red_end;
  logic       ped_req;
  logic       flash_en;
  logic       state_green;
  logic       state_yellow;
  logic       state_red;
  logic [2:0] main_lamp;
  logic [2:0] side_lamp;
  logic       walk;

  modport master (
    output green_end, yellow_end, red_end, ped_req, flash_en,
    input  state_green, state_yellow, state_red, main_lamp, side_lamp, walk
  );

  modport slave (
    input  green_end, yellow_end, red_end, ped_req, flash_en,
    output state_green, state_yellow, state_red, main_lamp, side_lamp, walk
  );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Two-road traffic light FSM with pedestrian walk phase and maintenance flashing.
// All outputs are registered from the next state so they change cleanly on the clock edge.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned FLASH_HALF = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  traffic_light_ctrl_if.slave  bus
);

  localparam logic [7:0] HALF_LAST = 8'(FLASH_HALF - 1);

  tl_state_e  state;
  tl_state_e  state_nx;
  logic [7:0] blink_cnt;
  logic [7:0] blink_cnt_nx;
  logic       blink_phase;
  logic       blink_phase_nx;
  logic       ped_d;
  logic       ped_pending;
  logic       ped_rise;

  assign ped_rise = bus.ped_req & ~ped_d;

  // Only the end pulse matching the current phase advances; flash_en overrides everything.
  always_comb begin
    state_nx = state;
    if (bus.flash_en) begin
      state_nx = FLASH;
    end else begin
      case (state)
        MAIN_G:  if (bus.green_end)  state_nx = MAIN_Y;
        MAIN_Y:  if (bus.yellow_end) state_nx = AR1;
        AR1:     if (bus.red_end)    state_nx = SIDE_G;
        SIDE_G:  if (bus.green_end)  state_nx = SIDE_Y;
        SIDE_Y:  if (bus.yellow_end) state_nx = AR2;
        AR2:     if (bus.red_end)    state_nx = MAIN_G;
        FLASH:   state_nx = AR2;
        default: state_nx = AR2;
      endcase
    end
  end

  // Blink timing restarts from the lit half on every FLASH entry.
  always_comb begin
    blink_cnt_nx   = 8'd0;
    blink_phase_nx = 1'b0;
    if (state_nx == FLASH && state == FLASH) begin
      if (blink_cnt == HALF_LAST) begin
        blink_cnt_nx   = 8'd0;
        blink_phase_nx = ~blink_phase;
      end else begin
        blink_cnt_nx   = blink_cnt + 8'd1;
        blink_phase_nx = blink_phase;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= AR2;
      ped_d            <= 1'b0;
      ped_pending      <= 1'b0;
      blink_cnt        <= 8'd0;
      blink_phase      <= 1'b0;
      bus.state_green  <= 1'b0;
      bus.state_yellow <= 1'b0;
      bus.state_red    <= 1'b1;
      bus.main_lamp    <= LAMP_R;
      bus.side_lamp    <= LAMP_R;
      bus.walk         <= 1'b0;
    end else begin
      state       <= state_nx;
      ped_d       <= bus.ped_req;
      blink_cnt   <= blink_cnt_nx;
      blink_phase <= blink_phase_nx;

      // SIDE_G entry consumes the pending request, but a fresh press on the same edge wins.
      if (state_nx == FLASH && state != FLASH) begin
        ped_pending <= 1'b0;
      end else if (state_nx == SIDE_G && state != SIDE_G) begin
        ped_pending <= ped_rise;
      end else if (ped_rise) begin
        ped_pending <= 1'b1;
      end

      bus.state_green  <= (state_nx == MAIN_G) || (state_nx == SIDE_G);
      bus.state_yellow <= (state_nx == MAIN_Y) || (state_nx == SIDE_Y);
      bus.state_red    <= (state_nx == AR1)    || (state_nx == AR2);
      {bus.main_lamp, bus.side_lamp} <= lamps_of(state_nx, ~blink_phase_nx);
      bus.walk <= (state_nx == SIDE_G) && ((state != SIDE_G) ? ped_pending : bus.walk);
    end
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Randomized scoreboard bench for traffic_light_ctrl: the driver pushes model predictions,
// a monitor pops and compares one prediction per clock.
module tb_traffic_light_ctrl;

  localparam int FLASH_HALF = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  traffic_light_ctrl_if bus();

  traffic_light_ctrl #(.FLASH_HALF(FLASH_HALF)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Expected packing: {state_green, state_yellow, state_red, main_lamp, side_lamp, walk}
  logic [9:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  // Reference model: position in the six-phase ring (0 main green .. 5 second all-red).
  logic [2:0] main_tab[6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] side_tab[6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
  int m_pos = 5;
  bit m_flash = 1'b0;
  int m_age = 0;
  bit m_pend = 1'b0;
  bit m_prev = 1'b0;
  bit m_walk = 1'b0;

  bit ped_lvl = 1'b0;
  bit flash_lvl = 1'b0;

  task automatic applyStimulus(input bit rst, input bit g, input bit y, input bit r,
                               input bit ped, input bit fl);
    bit rise;
    bit pulse;
    bit on;
    logic [9:0] e;
    @(negedge clk);
    rst_n          = rst;
    bus.green_end  = g;
    bus.yellow_end = y;
    bus.red_end    = r;
    bus.ped_req    = ped;
    bus.flash_en   = fl;
    if (!rst) begin
      m_pos = 5; m_flash = 0; m_age = 0; m_pend = 0; m_prev = 0; m_walk = 0;
    end else begin
      rise = ped && !m_prev;
      m_prev = ped;
      if (fl) begin
        if (!m_flash) begin
          m_flash = 1; m_age = 0; m_pend = 0;
        end else begin
          m_age++;
          if (rise) m_pend = 1;
        end
        m_walk = 0;
      end else if (m_flash) begin
        m_flash = 0; m_pos = 5; m_walk = 0;
        if (rise) m_pend = 1;
      end else begin
        case (m_pos % 3)
          0:       pulse = g;
          1:       pulse = y;
          default: pulse = r;
        endcase
        if (pulse) begin
          m_pos = (m_pos + 1) % 6;
          if (m_pos == 3) begin
            m_walk = m_pend;
            m_pend = rise;
          end else begin
            m_walk = 0;
            if (rise) m_pend = 1;
          end
        end else if (rise) begin
          m_pend = 1;
        end
      end
    end
    if (m_flash) begin
      on = ((m_age / FLASH_HALF) % 2) == 0;
      e = {3'b000, on ? 3'b010 : 3'b000, on ? 3'b100 : 3'b000, 1'b0};
    end else begin
      e = {(m_pos % 3) == 0, (m_pos % 3) == 1, (m_pos % 3) == 2,
           main_tab[m_pos], side_tab[m_pos], m_walk};
    end
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input logic [9:0] exp);
    logic [9:0] act;
    act = {bus.state_green, bus.state_yellow, bus.state_red,
           bus.main_lamp, bus.side_lamp, bus.walk};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL outputs @%0t: got gyr=%b main=%b side=%b walk=%b, want gyr=%b main=%b side=%b walk=%b",
               $time, act[9:7], act[6:4], act[3:1], act[0], exp[9:7], exp[6:4], exp[3:1], exp[0]);
    end
  endtask

  task automatic step(input bit g, input bit y, input bit r);
    applyStimulus(1'b1, g, y, r, ped_lvl, flash_lvl);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic fullCycle();
    step(1, 0, 0); idle(1); step(0, 1, 0); idle(1); step(0, 0, 1); idle(2);
    step(1, 0, 0); idle(1); step(0, 1, 0); idle(1); step(0, 0, 1); idle(1);
  endtask

  // Monitor: one prediction per clock, sampled just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (done) break;
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.green_end = 0; bus.yellow_end = 0; bus.red_end = 0;
    bus.ped_req = 0; bus.flash_en = 0;

    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 1, 1, 0);
    idle(2);
    step(0, 0, 1);
    idle(2);
    fullCycle();

    // Held pedestrian button during main green gives exactly one walk phase.
    ped_lvl = 1; idle(20); ped_lvl = 0;
    step(1, 0, 0); step(0, 1, 0); step(0, 0, 1); idle(3);
    step(1, 0, 0); step(0, 1, 0); step(0, 0, 1);
    step(1, 0, 0); step(0, 1, 0); step(0, 0, 1); idle(2);
    step(1, 0, 0); step(0, 1, 0); step(0, 0, 1); idle(1);

    // Stray pulses in main green, then green_end with flash_en.
    step(0, 1, 0); step(0, 0, 1); idle(1);
    flash_lvl = 1; step(1, 0, 0); idle(20);
    flash_lvl = 0; step(0, 0, 1); idle(2);

    // Reset while walking in side green, then reset while flashing.
    step(0, 0, 1);
    ped_lvl = 1; idle(1); ped_lvl = 0;
    step(1, 0, 0); step(0, 1, 0); step(0, 0, 1); idle(2);
    applyStimulus(0, 0, 0, 0, 0, 0);
    idle(2);
    flash_lvl = 1; idle(6);
    applyStimulus(0, 0, 0, 0, 0, 1);
    idle(3);
    flash_lvl = 0; idle(2);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) ped_lvl = ~ped_lvl;
      if ($urandom_range(0, 39) == 0) flash_lvl = ~flash_lvl;
      applyStimulus($urandom_range(0, 299) != 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) == 0, ped_lvl, flash_lvl);
    end

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending predictions, want 0", exp_q.size());
    end
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
